// File: rtl/serial_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// serial_multiplier_pkg
//   Definitions shared by the serial multiplier and the modular-reduction
//   stage that consumes its product:
//     DEFAULT_WIDTH  - default operand width in bits
//     mult_state_t   - controller state encoding (IDLE, RUN, SIGN, DONE)
// ---------------------------------------------------------------------------
package serial_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } mult_state_t;

endpackage : serial_multiplier_pkg

// File: rtl/serial_multiplier.sv
// ---------------------------------------------------------------------------
// serial_multiplier
//   Signed shift-and-add multiplier, one multiplier bit per clock.
//   The magnitudes of both operands are multiplied unsigned, and the sign is
//   applied once at the end, so the most negative operand needs no special
//   handling.
//
// Ports
//   clk     in   1        clock, rising edge
//   reset   in   1        synchronous, active-high reset
//   enable  in   1        start request, only looked at while idle
//   a       in   width    signed multiplicand
//   b       in   width    signed multiplier
//   busy    out  1        high while the operation is in RUN or SIGN
//   done    out  1        one-cycle completion pulse
//   product out  2*width  signed a*b, held until the next result is written
// ---------------------------------------------------------------------------
module serial_multiplier
  import serial_multiplier_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [width-1:0]     a,
  input  logic [width-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*width-1:0]   product
);

  // One extra counter bit so the full count 0..width fits.
  localparam int                 CW       = $clog2(width) + 1;
  localparam logic [CW-1:0]      LAST_CNT = CW'(width - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [width-1:0]   ONE_W    = {{(width-1){1'b0}}, 1'b1};
  localparam logic [2*width-1:0] ONE_2W   = {{(2*width-1){1'b0}}, 1'b1};

  mult_state_t            state_r;
  logic [2*width-1:0]     mcand_r;    // multiplicand magnitude, shifted left each step
  logic [width-1:0]       mplier_r;   // multiplier magnitude, shifted right each step
  logic [2*width-1:0]     acc_r;      // unsigned partial-product accumulator
  logic [CW-1:0]          cnt_r;
  logic                   neg_r;
  logic                   busy_r;
  logic                   done_r;
  logic [2*width-1:0]     product_r;

  logic [width-1:0]       abs_a_s;
  logic [width-1:0]       abs_b_s;
  logic [2*width-1:0]     acc_sum_s;
  logic [2*width-1:0]     signed_prod_s;

  // Operand magnitudes; -2^(width-1) negates to itself, which read as
  // unsigned is exactly 2^(width-1).
  always_comb begin
    abs_a_s = a;
    abs_b_s = b;
    if (a[width-1]) begin
      abs_a_s = ~a + ONE_W;
    end else begin
      abs_a_s = a;
    end
    if (b[width-1]) begin
      abs_b_s = ~b + ONE_W;
    end else begin
      abs_b_s = b;
    end
  end

  // Next accumulator value for the current multiplier bit, and the final
  // signed result; negating zero yields zero, so no negative-zero case.
  always_comb begin
    acc_sum_s     = acc_r;
    signed_prod_s = acc_r;
    if (mplier_r[0]) begin
      acc_sum_s = acc_r + mcand_r;
    end else begin
      acc_sum_s = acc_r;
    end
    if (neg_r) begin
      signed_prod_s = ~acc_r + ONE_2W;
    end else begin
      signed_prod_s = acc_r;
    end
  end

  // Controller and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      mcand_r   <= {(2*width){1'b0}};
      mplier_r  <= {width{1'b0}};
      acc_r     <= {(2*width){1'b0}};
      cnt_r     <= {CW{1'b0}};
      neg_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {(2*width){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (enable) begin
            mcand_r  <= {{width{1'b0}}, abs_a_s};
            mplier_r <= abs_b_s;
            neg_r    <= a[width-1] ^ b[width-1];
            acc_r    <= {(2*width){1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= ST_RUN;
          end else begin
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r    <= acc_sum_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            state_r <= ST_SIGN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_SIGN: begin
          product_r <= signed_prod_s;
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule : serial_multiplier
